// File: rtl/glink_frame_tx_if.sv
// glink_frame_tx_if: controller write side, link enable and TLK transmit side of the G-Link framer
interface glink_frame_tx_if;
   logic [15:0] din;
   logic        din_valid;
   logic        din_last;
   logic        link_en;
   logic        full;
   logic        overflow;
   logic [15:0] gout;
   logic        tx_enable;
   logic        tx_error;
   logic [15:0] frame_cnt;
   modport master (output din, din_valid, din_last, link_en,
                   input  full, overflow, gout, tx_enable, tx_error, frame_cnt);
   modport slave  (input  din, din_valid, din_last, link_en,
                   output full, overflow, gout, tx_enable, tx_error, frame_cnt);
endinterface

// File: rtl/glink_frame_tx.sv
// glink_frame_tx: buffers event words and sends each event as a TLK burst with a CRC-16 trailer and an inter-frame gap
module glink_frame_tx #(
   parameter int          ADDR_W    = 4,
   parameter int          GAP_MIN   = 2,
   parameter logic [15:0] IDLE_WORD = 16'h0000
) (
   input logic clk,
   input logic rst,
   glink_frame_tx_if.slave bus
);
   localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] DEPTH_M1 = {1'b0, {ADDR_W{1'b1}}};
   typedef enum logic [1:0] {IDLE, SEND, CRC, GAP} state_t;
   state_t state, state_n;
   // entry = {write-side frame_bad (meaningful on LAST only), last, data}
   logic [17:0]       mem [2**ADDR_W];
   logic [17:0]       head;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   cnt, cplt;
   logic [15:0]       crc, crc_n, gout_n, frame_cnt;
   logic [7:0]        gap_cnt, gap_n;
   logic              wr, drop, pop, wr_bad, rd_bad, rd_bad_n, tx_en_n, tx_er_n;
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 15; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return r;
   endfunction
   assign head          = mem[rd_ptr];
   assign bus.full      = cnt >= DEPTH_M1;
   // the final slot is reserved for an end-of-event word
   assign wr            = bus.din_valid & (bus.din_last ? cnt != DEPTH : cnt < DEPTH_M1);
   assign drop          = bus.din_valid & ~wr;
   assign bus.frame_cnt = frame_cnt;
   always_comb begin
      state_n  = state;
      gout_n   = IDLE_WORD;
      tx_en_n  = 1'b0;
      tx_er_n  = 1'b0;
      crc_n    = crc;
      rd_bad_n = rd_bad;
      gap_n    = gap_cnt;
      pop      = 1'b0;
      case (state)
         IDLE, SEND: begin
            pop = (state == IDLE) ? bus.link_en & (|cplt | bus.full) : |cnt;
            if (pop) begin
               gout_n   = head[15:0];
               tx_en_n  = 1'b1;
               crc_n    = crc_step((state == IDLE) ? 16'h0000 : crc, head[15:0]);
               state_n  = head[16] ? CRC : SEND;
               rd_bad_n = rd_bad | (head[16] & head[17]);
            end
         end
         CRC: begin
            gout_n   = crc;
            tx_en_n  = 1'b1;
            tx_er_n  = rd_bad;
            crc_n    = 16'h0000;
            rd_bad_n = 1'b0;
            gap_n    = 8'd0;
            state_n  = GAP;
         end
         default: begin
            gap_n   = gap_cnt + 8'd1;
            state_n = (gap_cnt == 8'(GAP_MIN - 1)) ? IDLE : GAP;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         cnt           <= '0;
         cplt          <= '0;
         crc           <= 16'h0000;
         rd_bad        <= 1'b0;
         wr_bad        <= 1'b0;
         gap_cnt       <= 8'd0;
         frame_cnt     <= 16'h0000;
         bus.gout      <= IDLE_WORD;
         bus.tx_enable <= 1'b0;
         bus.tx_error  <= 1'b0;
         bus.overflow  <= 1'b0;
      end else begin
         state         <= state_n;
         wr_ptr        <= wr_ptr + {{(ADDR_W-1){1'b0}}, wr};
         rd_ptr        <= rd_ptr + {{(ADDR_W-1){1'b0}}, pop};
         cnt           <= cnt + {{ADDR_W{1'b0}}, wr} - {{ADDR_W{1'b0}}, pop};
         cplt          <= cplt + {{ADDR_W{1'b0}}, wr & bus.din_last} - {{ADDR_W{1'b0}}, pop & head[16]};
         crc           <= crc_n;
         rd_bad        <= rd_bad_n;
         wr_bad        <= drop | (wr_bad & ~(wr & bus.din_last));
         gap_cnt       <= gap_n;
         frame_cnt     <= frame_cnt + 16'(state == CRC);
         bus.gout      <= gout_n;
         bus.tx_enable <= tx_en_n;
         bus.tx_error  <= tx_er_n;
         bus.overflow  <= bus.overflow | drop;
      end
   end
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= {wr_bad, bus.din_last, bus.din};
   end
endmodule

// File: tb/tb_glink_frame_tx.sv
// tb_glink_frame_tx: vector table for basic framing plus directed multi-cycle sequences
module tb_glink_frame_tx;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   glink_frame_tx_if bus();
   glink_frame_tx dut (.clk(clk), .rst(rst), .bus(bus.slave));
   typedef struct {
      logic        rst, link, v, l;
      logic [15:0] d;
      logic [15:0] eg;
      logic        een, eer;
      logic [15:0] efc;
   } vec_t;
   vec_t tbl [17];
   int total = 0;
   int bad = 0;
   logic [16:0] txq [$];
   logic [15:0] w [$];
   // every transmitted word as {tx_error, gout}
   always @(negedge clk) if (bus.tx_enable) txq.push_back({bus.tx_error, bus.gout});
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      txq.delete();
   endtask
   task automatic wr(input logic [15:0] d, input logic l);
      bus.din = d;
      bus.din_valid = 1'b1;
      bus.din_last = l;
      tick();
      bus.din_valid = 1'b0;
      bus.din_last = 1'b0;
   endtask
   function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [15:0] d);
      logic [15:0] r;
      r = c ^ d;
      for (int k = 0; k < 16; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction
   task automatic wait_q(input string nm, input int n, input int budget);
      int k = 0;
      while (txq.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk({nm, "_len"}, txq.size(), n);
   endtask
   task automatic check_frame(input string nm, input logic er);
      logic [15:0] c = 16'h0000;
      int n = w.size() + 1;
      wait_q(nm, n, 60);
      for (int i = 0; i < w.size(); i++) begin
         if (i < txq.size()) chk($sformatf("%s_w%0d", nm, i), txq[i], {1'b0, w[i]});
         c = crc_model(c, w[i]);
      end
      if (txq.size() >= n) chk({nm, "_crc"}, txq[n-1], {er, c});
      repeat (n) if (txq.size() != 0) void'(txq.pop_front());
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end
   initial begin
      rst = 1'b0;
      bus.din = 16'h0;
      bus.din_valid = 1'b0;
      bus.din_last = 1'b0;
      bus.link_en = 1'b0;
      tbl[0]  = '{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd0};
      tbl[1]  = '{0, 1, 1, 1, 16'h0001, 16'h0000, 0, 0, 16'd0};
      tbl[2]  = '{0, 1, 0, 0, 16'h0000, 16'h0001, 1, 0, 16'd0};
      tbl[3]  = '{0, 1, 0, 0, 16'h0000, 16'h1021, 1, 0, 16'd1};
      tbl[4]  = '{0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd1};
      tbl[5]  = '{0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd1};
      tbl[6]  = '{0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, 16'd1};
      tbl[7]  = '{0, 1, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'd1};
      tbl[8]  = '{0, 1, 1, 1, 16'h0001, 16'h0000, 1, 0, 16'd1};
      tbl[9]  = '{0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'd1};
      tbl[10] = '{0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'd2};
      tbl[11] = '{0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd2};
      tbl[12] = '{0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd2};
      tbl[13] = '{0, 1, 0, 0, 16'h0000, 16'h0001, 1, 0, 16'd2};
      tbl[14] = '{0, 1, 0, 0, 16'h0000, 16'h1021, 1, 0, 16'd3};
      tbl[15] = '{0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd3};
      tbl[16] = '{0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd3};
      for (int i = 0; i < 17; i++) begin
         rst = tbl[i].rst;
         bus.link_en = tbl[i].link;
         bus.din_valid = tbl[i].v;
         bus.din_last = tbl[i].l;
         bus.din = tbl[i].d;
         tick();
         chk($sformatf("vec%0d_gout", i), bus.gout, tbl[i].eg);
         chk($sformatf("vec%0d_txen", i), bus.tx_enable, tbl[i].een);
         chk($sformatf("vec%0d_txer", i), bus.tx_error, tbl[i].eer);
         chk($sformatf("vec%0d_fcnt", i), bus.frame_cnt, tbl[i].efc);
      end
      rst = 1'b0;
      bus.din_valid = 1'b0;
      bus.din_last = 1'b0;
      chk("vec_overflow", bus.overflow, 0);
      // cut-through of a 15-word head, underrun, then the LAST word
      do_reset();
      bus.link_en = 1'b1;
      for (int i = 1; i <= 15; i++) wr(16'h0100 + 16'(i), 1'b0);
      chk("ct_full", bus.full, 1);
      wait_q("ct_head", 15, 40);
      tick();
      tick();
      chk("ct_underrun_en", bus.tx_enable, 0);
      chk("ct_empty_full", bus.full, 0);
      wr(16'h00aa, 1'b1);
      w.delete();
      for (int i = 1; i <= 15; i++) w.push_back(16'h0100 + 16'(i));
      w.push_back(16'h00aa);
      check_frame("ct", 1'b0);
      chk("ct_overflow", bus.overflow, 0);
      chk("ct_fcnt", bus.frame_cnt, 1);
      // overflow: 15 plain words stored, 4 dropped, LAST kept in the reserved slot
      do_reset();
      bus.link_en = 1'b0;
      for (int i = 1; i <= 20; i++) wr(16'h0200 + 16'(i), i == 20);
      chk("ov_flag", bus.overflow, 1);
      chk("ov_full", bus.full, 1);
      chk("ov_held", txq.size(), 0);
      bus.link_en = 1'b1;
      w.delete();
      for (int i = 1; i <= 15; i++) w.push_back(16'h0200 + 16'(i));
      w.push_back(16'h0214);
      check_frame("ov", 1'b1);
      wr(16'h1234, 1'b1);
      w.delete();
      w.push_back(16'h1234);
      check_frame("ov_next", 1'b0);
      chk("ov_sticky", bus.overflow, 1);
      // link enable dropped mid-frame, then gating of a queued frame
      do_reset();
      bus.link_en = 1'b1;
      for (int i = 1; i <= 4; i++) wr(16'h0300 + 16'(i), i == 4);
      tick();
      bus.link_en = 1'b0;
      w.delete();
      for (int i = 1; i <= 4; i++) w.push_back(16'h0300 + 16'(i));
      check_frame("le_mid", 1'b0);
      repeat (3) tick();
      wr(16'h0401, 1'b0);
      wr(16'h0402, 1'b1);
      repeat (10) tick();
      chk("le_hold", txq.size(), 0);
      chk("le_hold_en", bus.tx_enable, 0);
      bus.link_en = 1'b1;
      w.delete();
      w.push_back(16'h0401);
      w.push_back(16'h0402);
      check_frame("le_go", 1'b0);
      chk("le_fcnt", bus.frame_cnt, 2);
      // reset in the middle of a frame
      do_reset();
      bus.link_en = 1'b1;
      for (int i = 1; i <= 4; i++) wr(16'h0500 + 16'(i), i == 4);
      tick();
      tick();
      chk("rm_sending", bus.tx_enable, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rm_gout", bus.gout, 16'h0000);
      chk("rm_txen", bus.tx_enable, 0);
      chk("rm_fcnt", bus.frame_cnt, 0);
      txq.delete();
      repeat (10) tick();
      chk("rm_empty", txq.size(), 0);
      chk("rm_fcnt_after", bus.frame_cnt, 0);
      // frame counter wrap
      force dut.frame_cnt = 16'hfffe;
      tick();
      release dut.frame_cnt;
      wr(16'h0601, 1'b1);
      w.delete();
      w.push_back(16'h0601);
      check_frame("wrap1", 1'b0);
      chk("wrap_ffff", bus.frame_cnt, 16'hffff);
      repeat (3) tick();
      wr(16'h0602, 1'b1);
      w.delete();
      w.push_back(16'h0602);
      check_frame("wrap2", 1'b0);
      chk("wrap_zero", bus.frame_cnt, 16'h0000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
